if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction fetch stage; the producer that drives if_decoder_instruction into the decoder.
- Holds the PC and issues word reads to instruction memory over a valid/ready request channel with in-order responses.
- Buffers fetched words in a small prefetch FIFO and presents them to the decoder with a valid/ready handshake.
- Accepts a redirect (branch) that flushes the FIFO and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response data valid; responses arrive in request order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- if_decoder_instruction  output  32  FIFO head instruction.
- if_decoder_pc  output  32  address of the head instruction.
- if_decoder_valid  output  1  head entry valid.
- decoder_if_ready  input  1  decoder consumes the head this cycle.
- redirect_valid  input  1  branch/redirect strobe, 1 cycle.
- redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 0).

Behaviour:
- Reset, asynchronous:
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0; state = IDLE.
  - Outputs: imem_req_valid = 0, imem_req_addr = RESET_PC, if_decoder_valid = 0, if_decoder_instruction = 0, if_decoder_pc = 0.
  - Reset mid-operation discards all state; responses still in flight are the memory's responsibility.
- FSM:
  - IDLE: one cycle after reset release, then RUN.
  - RUN: issue requests.
  - DRAIN: after a redirect while drop_cnt > 0, discard stale responses; no new requests. Go to RUN in the cycle drop_cnt reaches 0.
- Request rule:
  - imem_req_valid = (state == RUN) && (fifo_count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
  - imem_req_valid may drop without a handshake only because of redirect or credit loss.
- Response rule:
  - In RUN, imem_rsp_valid pushes {data, pc} into the FIFO; outstanding -= 1.
  - The entry pc comes from a rsp_pc register that advances by 4 per response and reloads on redirect.
  - The credit rule guarantees the FIFO never overflows; an overflow indicates a bug.
- Decoder side:
  - Head is visible combinationally from FIFO storage; pop on if_decoder_valid && decoder_if_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When the FIFO is empty, a response is not forwarded in the same cycle; 1-cycle minimum latency from rsp to if_decoder_valid.
- Redirect, with priority over all same-cycle events:
  - FIFO cleared; pointers reset; if_decoder_valid = 0 next cycle.
  - fetch_pc and rsp_pc loaded with {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding + (request handshake this cycle) - (response this cycle).
  - Next state is DRAIN if drop_cnt > 0, else RUN. Any request handshake in the redirect cycle is counted as stale.
  - A redirect while in DRAIN reloads the PC; drop_cnt keeps counting the remaining outstanding responses.
- Responses in DRAIN: decrement drop_cnt and outstanding; data discarded.
- Widths: outstanding and drop_cnt are PTR_W+1 bits; fifo_count is PTR_W+1 bits.

Optional Feature:
- IF_PERF_CNT_EN.
- Defined:
  - Extra output perf_fetch_cnt[31:0] counts decoder pops.
  - Extra output perf_stall_cnt[31:0] counts cycles with decoder_if_ready=1 and if_decoder_valid=0.
  - Both reset to 0 and wrap.
- Undefined: ports and logic absent; no other behaviour change.

Decomposition:
- Shared package:
  - FSM state encoding constants IF_IDLE = 2'd0, IF_RUN = 2'd1, IF_DRAIN = 2'd2.
  - Instruction width constant 32.
  - PC increment constant 4.
- Sub-module: if_prefetch_fifo, a DEPTH x 64-bit synchronous FIFO with push, pop, flush, count, and head outputs.
- The FSM, credit and PC logic stay in the top module.

Test Plan:
- Reset release, imem_req_ready=1, responses 1 cycle after each request, decoder_if_ready=1 -> requests at 0x0, 0x4, 0x8…; decoder sees pc 0x0 with its data 2 cycles after the first request, then one instruction per cycle.
- decoder_if_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, imem_req_valid low afterwards; FIFO holds pcs 0x0–0xC; release -> in-order pops and fetching resumes at 0x10.
- imem_req_ready toggled 1010…, response latency 3 cycles -> no lost or duplicated pcs; fifo_count + outstanding is never > 4.
- Redirect to 0x103 with 2 responses outstanding -> FIFO empty next cycle; 2 responses dropped in DRAIN; next request addr 0x100; first decoder pc 0x100.
- Redirect in the same cycle as a request handshake and a response -> drop_cnt computed correctly; no stale instruction reaches the decoder.
- rst_n asserted low mid-stream with a full FIFO -> all outputs return to reset values immediately (asynchronously); fetch restarts from RESET_PC after release.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   if_state_e    : fetch FSM states (IDLE / RUN / DRAIN)
//   INSTR_W       : instruction word width
//   PC_INC        : byte increment between sequential fetch addresses
//   fetch_entry_t : one prefetch FIFO entry {instruction, pc}
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_RUN   = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO: DEPTH x WIDTH synchronous FIFO with flush.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push       : write push_data at the tail
//   pop        : advance the head (caller only pops when non-empty)
//   flush      : empty the FIFO; has priority over push and pop
//   count      : number of valid entries (0..DEPTH)
//   head       : storage at the read pointer, visible combinationally
//   empty      : count == 0
module if_prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues word reads to instruction
// memory under a credit limit, buffers responses in a prefetch FIFO and
// presents them to the decoder. A redirect flushes the FIFO and discards
// responses to requests issued before it.
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_req_valid/addr     : fetch request (word aligned)
//   imem_req_ready          : memory accepts the request
//   imem_rsp_valid/data     : in-order response
//   if_decoder_instruction  : FIFO head instruction
//   if_decoder_pc           : FIFO head address
//   if_decoder_valid        : head entry valid
//   decoder_if_ready        : decoder consumes the head
//   redirect_valid/pc       : branch redirect strobe and target
// Optional build macro IF_PERF_CNT_EN adds:
//   perf_fetch_cnt          : decoder pops
//   perf_stall_cnt          : cycles with decoder ready but no valid head
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_decoder_instruction,
  output logic [31:0] if_decoder_pc,
  output logic        if_decoder_valid,
  input  logic        decoder_if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W:0]   ONE     = (PTR_W+1)'(1);

  if_state_e    state;
  logic [31:0]  fetch_pc;
  logic [31:0]  rsp_pc;
  logic [PTR_W:0] outstanding;
  logic [PTR_W:0] drop_cnt;
  logic [PTR_W:0] out_next;
  logic [PTR_W:0] fifo_count;
  logic [31:0]  redirect_aligned;
  logic         req_hs;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [63:0]  fifo_head;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Credit check covers both buffered entries and in-flight responses,
  // so every accepted request is guaranteed a FIFO slot.
  assign imem_req_valid = (state == IF_RUN) &&
                          (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_L);
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  always_comb begin
    out_next = outstanding;
    if (req_hs && !imem_rsp_valid) begin
      out_next = outstanding + ONE;
    end else if (!req_hs && imem_rsp_valid) begin
      out_next = outstanding - ONE;
    end
  end

  assign fifo_push        = imem_rsp_valid && (state == IF_RUN) && !redirect_valid;
  assign fifo_pop         = if_decoder_valid && decoder_if_ready && !redirect_valid;
  assign push_entry.instr = imem_rsp_data;
  assign push_entry.pc    = rsp_pc;

  if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  assign head_entry             = fetch_entry_t'(fifo_head);
  assign if_decoder_valid       = !fifo_empty;
  assign if_decoder_instruction = head_entry.instr;
  assign if_decoder_pc          = head_entry.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IF_IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Everything still owed by memory, including a request accepted in
        // this very cycle, belongs to the old path and must be dropped.
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        drop_cnt <= out_next;
        state    <= (out_next != '0) ? IF_DRAIN : IF_RUN;
      end else begin
        if (req_hs) begin
          fetch_pc <= fetch_pc + PC_INC;
        end
        unique case (state)
          IF_IDLE: state <= IF_RUN;
          IF_RUN: begin
            if (imem_rsp_valid) begin
              rsp_pc <= rsp_pc + PC_INC;
            end
          end
          IF_DRAIN: begin
            if (imem_rsp_valid) begin
              drop_cnt <= drop_cnt - ONE;
              if (drop_cnt == ONE) begin
                state <= IF_RUN;
              end
            end
          end
          default: state <= IF_IDLE;
        endcase
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fifo_pop) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (decoder_if_ready && !if_decoder_valid) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] if_decoder_instruction;
  logic [31:0] if_decoder_pc;
  logic        if_decoder_valid;
  logic        decoder_if_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .PTR_W    (2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .imem_req_valid         (imem_req_valid),
    .imem_req_addr          (imem_req_addr),
    .imem_req_ready         (imem_req_ready),
    .imem_rsp_valid         (imem_rsp_valid),
    .imem_rsp_data          (imem_rsp_data),
    .if_decoder_instruction (if_decoder_instruction),
    .if_decoder_pc          (if_decoder_pc),
    .if_decoder_valid       (if_decoder_valid),
    .decoder_if_ready       (decoder_if_ready),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt         (perf_fetch_cnt),
    .perf_stall_cnt         (perf_stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Memory contents: every word depends on its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory + reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        q[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  int          rdy_mode = 0;   // 0 always, 1 alternate, 2 random, 3 never
  int          dr_mode = 1;    // 0 never, 1 always, 2 random
  int          rsp_pct = 100;
  bit          rsp_hold = 0;
  int          redir_pct = 0;  // per mille
  bit          redir_now = 0;
  logic [31:0] redir_target = '0;

  logic [31:0] exp_req, exp_dec;
  int          live_unpopped, avail;
  bit          in_idle;
  int          hs_cnt, pop_cnt;
  bit          got_hs, got_pop;
  logic [31:0] first_hs_addr, first_pop_pc;

  task automatic model_reset();
    q.delete();
    exp_req       = RESET_PC;
    exp_dec       = RESET_PC;
    live_unpopped = 0;
    avail         = 0;
    in_idle       = 1;
    hs_cnt        = 0;
    pop_cnt       = 0;
    got_hs        = 0;
    got_pop       = 0;
  endtask

  task automatic drive_idle_inputs();
    imem_req_ready   = 1'b0;
    imem_rsp_valid   = 1'b0;
    decoder_if_ready = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_req_addr"},  imem_req_addr, RESET_PC);
    chk({tag, "_dec_valid"}, if_decoder_valid, 0);
    chk({tag, "_dec_instr"}, if_decoder_instruction, 0);
    chk({tag, "_dec_pc"},    if_decoder_pc, 0);
  endtask

  // Reset released just after a rising edge so the next sampled cycle is IDLE.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle_inputs();
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive inputs at the falling edge, sample 1ns later, then
  // update the model with the events that the next rising edge commits.
  task automatic step();
    bit          fire, redir, hs;
    int          stale_n, occ;
    req_t        e;
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    fire = 0;
    if (!rsp_hold && q.size() > 0 && q[0].due <= cyc && int'($urandom_range(99)) < rsp_pct)
      fire = 1;
    imem_rsp_valid = fire;
    imem_rsp_data  = fire ? mem_word(q[0].addr) : $urandom();
    case (rdy_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = (cyc % 2 == 0);
      2:       imem_req_ready = 1'($urandom_range(1));
      default: imem_req_ready = 1'b0;
    endcase
    case (dr_mode)
      0:       decoder_if_ready = 1'b0;
      1:       decoder_if_ready = 1'b1;
      default: decoder_if_ready = 1'($urandom_range(1));
    endcase
    redir          = redir_now || (int'($urandom_range(999)) < redir_pct);
    redirect_valid = redir;
    redirect_pc    = redir_now ? redir_target : $urandom();
    tgt            = redirect_pc & 32'hFFFF_FFFC;
    #1;

    stale_n = 0;
    foreach (q[i]) if (q[i].stale) stale_n++;
    occ = live_unpopped + stale_n;
    chk("req_valid", imem_req_valid, (!in_idle && stale_n == 0 && occ < DEPTH));
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
    chk("dec_valid", if_decoder_valid, (avail > 0));

    if (if_decoder_valid && decoder_if_ready && !redir) begin
      chk("dec_pc", if_decoder_pc, exp_dec);
      chk("dec_instr", if_decoder_instruction, mem_word(exp_dec));
      if (!got_pop) begin
        got_pop      = 1;
        first_pop_pc = if_decoder_pc;
      end
      exp_dec = exp_dec + 32'd4;
      pop_cnt++;
      if (avail > 0) begin
        avail--;
        live_unpopped--;
      end
    end

    if (redir) foreach (q[i]) q[i].stale = 1;
    if (fire) begin
      e = q.pop_front();
      if (!e.stale) avail++;
    end
    hs = imem_req_valid && imem_req_ready;
    if (hs) begin
      hs_cnt++;
      if (!got_hs) begin
        got_hs        = 1;
        first_hs_addr = imem_req_addr;
      end
      q.push_back('{addr: imem_req_addr,
                    due: cyc + int'($urandom_range(lat_max, lat_min)),
                    stale: redir});
      if (!redir) begin
        live_unpopped++;
        exp_req = exp_req + 32'd4;
      end
    end
    if (redir) begin
      live_unpopped = 0;
      avail         = 0;
      exp_req       = tgt;
      exp_dec       = tgt;
    end
    in_idle   = 0;
    redir_now = 0;
  endtask

  task automatic set_mode(input int rm, input int lmin, input int lmax,
                          input int dm, input int rp, input int rdp);
    rdy_mode  = rm;
    lat_min   = lmin;
    lat_max   = lmax;
    dr_mode   = dm;
    rsp_pct   = rp;
    redir_pct = rdp;
    rsp_hold  = 0;
    redir_now = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        rdy;
    logic        dr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Back-to-back flow, 1-cycle memory latency, decoder always ready.
    tbl[0] = '{1'b0, 32'h0,               1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,               1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[2] = '{1'b1, mem_word(32'h00),    1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[3] = '{1'b1, mem_word(32'h04),    1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4] = '{1'b1, mem_word(32'h08),    1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5] = '{1'b1, mem_word(32'h0C),    1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6] = '{1'b1, mem_word(32'h10),    1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};

    model_reset();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      imem_rsp_valid   = tbl[i].rsp_v;
      imem_rsp_data    = tbl[i].rsp_d;
      imem_req_ready   = tbl[i].rdy;
      decoder_if_ready = tbl[i].dr;
      redirect_valid   = 1'b0;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].e_rv);
      chk($sformatf("tbl%0d_req_addr", i),  imem_req_addr,  tbl[i].e_addr);
      chk($sformatf("tbl%0d_dec_valid", i), if_decoder_valid, tbl[i].e_dv);
      if (tbl[i].e_dv) begin
        chk($sformatf("tbl%0d_dec_pc", i),    if_decoder_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_dec_instr", i), if_decoder_instruction, mem_word(tbl[i].e_pc));
      end
    end

    // Decoder stalled: only DEPTH requests may be issued.
    do_reset();
    set_mode(0, 1, 1, 0, 100, 0);
    repeat (10) step();
    chk("stall_hs_cnt", hs_cnt, DEPTH);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_head_pc", if_decoder_pc, 32'h0);
    dr_mode = 1;
    repeat (10) step();
    chk("stall_resume_pops", (pop_cnt >= 8), 1);

    // Alternating ready, 3-cycle latency.
    do_reset();
    set_mode(1, 3, 3, 1, 100, 0);
    repeat (80) step();
    chk("toggle_progress", (pop_cnt >= 20), 1);

    // Redirect to 0x103 with two responses outstanding.
    do_reset();
    set_mode(0, 3, 3, 1, 100, 0);
    for (int i = 0; i < 10 && q.size() != 2; i++) step();
    chk("redir2_outstanding", q.size(), 2);
    rdy_mode     = 3;
    rsp_hold     = 1;
    redir_now    = 1;
    redir_target = 32'h0000_0103;
    got_hs       = 0;
    got_pop      = 0;
    step();
    rsp_hold = 0;
    rdy_mode = 0;
    step();
    chk("redir2_dec_valid", if_decoder_valid, 0);
    chk("redir2_req_valid", imem_req_valid, 0);
    repeat (15) step();
    chk("redir2_got_hs", got_hs, 1);
    chk("redir2_first_addr", first_hs_addr, 32'h100);
    chk("redir2_got_pop", got_pop, 1);
    chk("redir2_first_pc", first_pop_pc, 32'h100);

    // Redirect coinciding with a request handshake and a response.
    do_reset();
    set_mode(0, 1, 1, 1, 100, 0);
    repeat (6) step();
    chk("redir_same_rsp_due", (q.size() > 0 && q[0].due <= cyc + 1), 1);
    chk("redir_same_fifo_busy", if_decoder_valid, 1);
    redir_now    = 1;
    redir_target = 32'h0000_2000;
    got_pop      = 0;
    step();
    step();
    chk("redir_same_dec_valid", if_decoder_valid, 0);
    repeat (15) step();
    chk("redir_same_first_pc", first_pop_pc, 32'h2000);

    // Long randomized run with occasional redirects.
    do_reset();
    set_mode(2, 1, 4, 2, 70, 15);
    repeat (3000) step();
    chk("random_progress", (pop_cnt > 100), 1);

    // Asynchronous reset with a full FIFO.
    do_reset();
    set_mode(0, 1, 1, 0, 100, 0);
    repeat (12) step();
    chk("full_dec_valid", if_decoder_valid, 1);
    chk("full_req_valid", imem_req_valid, 0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    drive_idle_inputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    set_mode(0, 1, 1, 1, 100, 0);
    repeat (10) step();
    chk("restart_first_addr", first_hs_addr, RESET_PC);
    chk("restart_first_pc", first_pop_pc, RESET_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
